// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the gray-pointer asynchronous FIFO (read clock domain only).
// Synchronises the write pointer, tracks occupancy and streams words out through a valid/ready register.
module fifo_rd_ctrl #(
    parameter int data_width  = 4,
    parameter int addr_width  = 2,
    parameter int sync_stages = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [addr_width:0]   wptr_gray,
    input  logic [data_width-1:0] rd_data,
    output logic [addr_width-1:0] rd_addr,
    output logic [addr_width:0]   rptr_gray,
    output logic                  rd_en,
    output logic [data_width-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  mem_empty,
    output logic [addr_width:0]   rd_count
);

    localparam int PW = addr_width + 1;

    // Handshake: a word moves downstream on every rising edge where data_valid && data_ready;
    // data_out is stable and data_valid stays high until that edge.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         sync_q [sync_stages];
    logic [PW-1:0]         wsync_gray;
    logic [PW-1:0]         wsync_bin;
    logic [PW-1:0]         rbin_q, rbin_d, rbin_inc;
    logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
    logic [data_width-1:0] data_out_q, data_out_d;

    // Plain flop chain: nothing else may look at wptr_gray before the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wsync_gray = sync_q[sync_stages-1];

    // Bit i of the binary value is the XOR of all gray bits at and above i.
    always_comb begin
        wsync_bin = '0;
        for (int i = 0; i < PW; i++) wsync_bin[i] = ^(wsync_gray >> i);
    end

    assign mem_empty  = (rptr_gray_q == wsync_gray);
    assign rd_count   = wsync_bin - rbin_q;
    assign rbin_inc   = rbin_q + PW'(1);
    assign data_valid = (state_q == HOLD);
    assign data_out   = data_out_q;
    assign rptr_gray  = rptr_gray_q;
    assign rd_addr    = rbin_q[addr_width-1:0];

    always_comb begin
        state_d     = state_q;
        data_out_d  = data_out_q;
        rbin_d      = rbin_q;
        rptr_gray_d = rptr_gray_q;
        rd_en       = 1'b0;
        if (!mem_empty && (state_q == IDLE || data_ready)) begin
            rd_en       = 1'b1;
            data_out_d  = rd_data;
            rbin_d      = rbin_inc;
            rptr_gray_d = rbin_inc ^ (rbin_inc >> 1);
            state_d     = HOLD;
        end else if (state_q == HOLD && data_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_out_q  <= '0;
            rbin_q      <= '0;
            rptr_gray_q <= '0;
        end else begin
            state_q     <= state_d;
            data_out_q  <= data_out_d;
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural RAM and write pointer drive the reader,
// and each observation is checked against hand-computed values.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] wptr_gray = '0;
  logic [3:0] rd_data;
  logic [1:0] rd_addr;
  logic [2:0] rptr_gray;
  logic       rd_en;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       mem_empty;
  logic [2:0] rd_count;

  logic [3:0] mem [4];
  logic [2:0] wbin = '0;
  logic [2:0] gtab [12];
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  fifo_rd_ctrl #(.data_width(4), .addr_width(2), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .wptr_gray(wptr_gray), .rd_data(rd_data),
    .rd_addr(rd_addr), .rptr_gray(rptr_gray), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .mem_empty(mem_empty), .rd_count(rd_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_wbin(input logic [2:0] b);
    wbin      = b;
    wptr_gray = b ^ (b >> 1);
  endtask

  task automatic do_reset();
    tick();
    rst        = 1'b1;
    data_ready = 1'b0;
    set_wbin(3'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    gtab = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101,
             3'b100, 3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // 1: reset asserted mid-cycle takes effect immediately
    #3 rst = 1'b1;
    #1;
    check("rst_valid", data_valid, 0);
    check("rst_empty", mem_empty, 1);
    check("rst_count", rd_count, 0);
    check("rst_rptr", rptr_gray, 0);
    check("rst_rden", rd_en, 0);
    check("rst_dout", data_out, 0);
    check("rst_addr", rd_addr, 0);
    tick();
    rst = 1'b0;

    // 2: single word, sync latency then one pop
    tick();
    mem[0]     = 4'hA;
    data_ready = 1'b1;
    set_wbin(3'd1);
    #1 check("t2_empty_now", mem_empty, 1);
    tick();
    check("t2_empty_1clk", mem_empty, 1);
    check("t2_rden_1clk", rd_en, 0);
    tick();
    check("t2_empty_2clk", mem_empty, 0);
    check("t2_rden_2clk", rd_en, 1);
    check("t2_count", rd_count, 1);
    check("t2_valid_pre", data_valid, 0);
    tick();
    check("t2_valid", data_valid, 1);
    check("t2_dout", data_out, 4'hA);
    check("t2_rptr", rptr_gray, 3'b001);
    check("t2_empty_after", mem_empty, 1);
    check("t2_count_after", rd_count, 0);
    tick();
    check("t2_idle", data_valid, 0);
    check("t2_dout_hold", data_out, 4'hA);

    // 3: full drain of four words
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 4'(i + 1);
    data_ready = 1'b1;
    set_wbin(3'd4);
    tick();
    tick();
    check("t3_count_full", rd_count, 4);
    check("t3_not_empty", mem_empty, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_valid", data_valid, 1);
      check("t3_dout", data_out, i + 1);
      check("t3_count", rd_count, 3 - i);
    end
    check("t3_empty_end", mem_empty, 1);
    check("t3_rptr_end", rptr_gray, 3'b110);
    check("t3_addr_end", rd_addr, 0);
    tick();
    check("t3_idle", data_valid, 0);

    // 4: backpressure holds the first word without loss or duplication
    do_reset();
    mem[0] = 4'h5; mem[1] = 4'h6; mem[2] = 4'h7;
    set_wbin(3'd3);
    tick();
    tick();
    check("t4_count3", rd_count, 3);
    check("t4_rden_idle", rd_en, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_stall_valid", data_valid, 1);
      check("t4_stall_dout", data_out, 4'h5);
      check("t4_stall_count", rd_count, 2);
      check("t4_stall_rden", rd_en, 0);
      tick();
    end
    data_ready = 1'b1;
    #1 check("t4_release_rden", rd_en, 1);
    tick();
    check("t4_dout2", data_out, 4'h6);
    check("t4_count2", rd_count, 1);
    tick();
    check("t4_dout3", data_out, 4'h7);
    check("t4_count3_end", rd_count, 0);
    check("t4_empty", mem_empty, 1);
    tick();
    check("t4_idle", data_valid, 0);

    // 5: twelve words across three laps, full RAM never reads as empty
    do_reset();
    data_ready = 1'b1;
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 4; i++) mem[i] = 4'(lap * 4 + i + 1);
      set_wbin(wbin + 3'd4);
      tick();
      tick();
      check("t5_count_full", rd_count, 4);
      check("t5_full_not_empty", mem_empty, 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        check("t5_dout", data_out, lap * 4 + i + 1);
        check("t5_rptr", rptr_gray, gtab[lap * 4 + i]);
        check("t5_addr", rd_addr, (i + 1) % 4);
      end
    end

    // 6: reset while a word is held discards it
    do_reset();
    mem[0] = 4'h9; mem[1] = 4'h8; mem[2] = 4'h7;
    set_wbin(3'd3);
    tick();
    tick();
    tick();
    check("t6_valid_pre", data_valid, 1);
    check("t6_count_pre", rd_count, 2);
    #2 rst = 1'b1;
    set_wbin(3'd0);
    #1;
    check("t6_valid_rst", data_valid, 0);
    check("t6_addr_rst", rd_addr, 0);
    check("t6_rptr_rst", rptr_gray, 0);
    check("t6_dout_rst", data_out, 0);
    check("t6_count_rst", rd_count, 0);
    tick();
    rst        = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_stale_valid", data_valid, 0);
      check("t6_no_stale_rden", rd_en, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
